// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/multu/div/divu
// over a fixed number of cycles and handles mthi/mtlo writes.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic        hl_busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               busy_r;
   logic [31:0]        hi_r;
   logic [31:0]        lo_r;
   logic [31:0]        pend_hi_r;
   logic [31:0]        pend_lo_r;
   logic               pend_wr_r;

   logic [63:0]        smul_s;
   logic [63:0]        umul_s;
   logic               sdiv_ovf_s;
   logic [31:0]        sdivisor_s;
   logic [31:0]        udivisor_s;
   logic signed [31:0] sdiv_q_s;
   logic signed [31:0] sdiv_r_s;
   logic [31:0]        udiv_q_s;
   logic [31:0]        udiv_r_s;
   logic               md_start_s;
   logic [31:0]        pend_hi_s;
   logic [31:0]        pend_lo_s;
   logic               pend_wr_s;
   logic [CNT_W-1:0]   load_s;

   assign smul_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
   assign umul_s = {32'h0000_0000, rs_data} * {32'h0000_0000, rt_data};

   // A zero divisor or the single signed overflow case divides by 1 instead:
   // rs/1 yields exactly 0x80000000 rem 0 for the overflow, and zero-divide results are discarded.
   assign sdiv_ovf_s = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
   assign sdivisor_s = ((rt_data == 32'h0000_0000) || sdiv_ovf_s) ? 32'h0000_0001 : rt_data;
   assign udivisor_s = (rt_data == 32'h0000_0000) ? 32'h0000_0001 : rt_data;
   assign sdiv_q_s   = $signed(rs_data) / $signed(sdivisor_s);
   assign sdiv_r_s   = $signed(rs_data) % $signed(sdivisor_s);
   assign udiv_q_s   = rs_data / udivisor_s;
   assign udiv_r_s   = rs_data % udivisor_s;

   // Select the pending result, commit enable and busy duration for the E-stage operation
   always_comb begin
      md_start_s = 1'b0;
      pend_hi_s  = 32'h0000_0000;
      pend_lo_s  = 32'h0000_0000;
      pend_wr_s  = 1'b0;
      load_s     = CNT_W'(MULT_CYCLES);
      case (md_op)
         4'd1: begin
            md_start_s = start;
            pend_hi_s  = smul_s[63:32];
            pend_lo_s  = smul_s[31:0];
            pend_wr_s  = 1'b1;
         end
         4'd2: begin
            md_start_s = start;
            pend_hi_s  = umul_s[63:32];
            pend_lo_s  = umul_s[31:0];
            pend_wr_s  = 1'b1;
         end
         4'd3: begin
            md_start_s = start;
            pend_hi_s  = sdiv_r_s;
            pend_lo_s  = sdiv_q_s;
            pend_wr_s  = (rt_data != 32'h0000_0000);
            load_s     = CNT_W'(DIV_CYCLES);
         end
         4'd4: begin
            md_start_s = start;
            pend_hi_s  = udiv_r_s;
            pend_lo_s  = udiv_q_s;
            pend_wr_s  = (rt_data != 32'h0000_0000);
            load_s     = CNT_W'(DIV_CYCLES);
         end
         default: begin
            md_start_s = 1'b0;
         end
      endcase
   end

   // Operation FSM: accept in IDLE, count down in RUN, commit HI/LO on the final edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         busy_r    <= 1'b0;
         hi_r      <= 32'h0000_0000;
         lo_r      <= 32'h0000_0000;
         pend_hi_r <= 32'h0000_0000;
         pend_lo_r <= 32'h0000_0000;
         pend_wr_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (md_start_s) begin
                  state_r   <= RUN;
                  cnt_r     <= load_s;
                  busy_r    <= 1'b1;
                  pend_hi_r <= pend_hi_s;
                  pend_lo_r <= pend_lo_s;
                  pend_wr_r <= pend_wr_s;
               end else if (md_op == 4'd5) begin
                  hi_r <= rs_data;
               end else if (md_op == 4'd6) begin
                  lo_r <= rs_data;
               end else begin
                  hi_r <= hi_r;
               end
            end
            RUN: begin
               cnt_r <= cnt_r - CNT_W'(1);
               if (cnt_r == CNT_W'(1)) begin
                  state_r   <= IDLE;
                  busy_r    <= 1'b0;
                  pend_wr_r <= 1'b0;
                  if (pend_wr_r) begin
                     hi_r <= pend_hi_r;
                     lo_r <= pend_lo_r;
                  end else begin
                     hi_r <= hi_r;
                  end
               end else begin
                  busy_r <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign hl_busy = start | busy_r;
   assign hi      = hi_r;
   assign lo      = lo_r;

endmodule
